// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, widths and the FIFO entry type shared by alu_issue_stage and its FIFO.
package alu_issue_pkg;
  localparam int OPC_W = 4;
  localparam int SHIFT_W = 5;
  localparam int DATA_W = 8;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OP_SLL = 4'd4;
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHIFT_W-1:0] shamt;
    logic               use_prev;
  } entry_t;
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: in-order circular-buffer FIFO of issue entries with an occupancy counter.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter type T = entry_t,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           data_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_comb begin
    wr_d = do_push ? wr_q + PW'(1) : wr_q;
    rd_d = do_pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: the head is only looked at when count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU packets, drives the combinational ALU from the FIFO head, registers its result.
// Define ALU_ISSUE_FWD_EN to let a packet take operand A from the previously issued result.
module alu_issue_stage
  import alu_issue_pkg::OPC_W;
#(
  parameter int WIDTH = alu_issue_pkg::DATA_W,
  parameter int DEPTH = 4,
  parameter int SHIFT_W = alu_issue_pkg::SHIFT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPC_W-1:0]           in_opcode,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [SHIFT_W-1:0]         in_shamt,
  input  logic                       in_use_prev,
  output logic [OPC_W-1:0]           alu_opcode,
  output logic [WIDTH-1:0]           alu_input1,
  output logic [WIDTH-1:0]           alu_input2,
  output logic [SHIFT_W-1:0]         alu_shift,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  input  logic                       alu_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_sign,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHIFT_W-1:0] shamt;
    logic               use_prev;
  } ent_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
  slot_e state_q, state_d;
  ent_t push_ent, head;
  logic full, empty, push, issue;
  logic [WIDTH-1:0] op_a, result_q, result_d;
  logic carry_q, zero_q, sign_q, carry_d, zero_d, sign_d;
  assign in_ready = !rst && !full;
  assign push = in_valid && in_ready;
  assign issue = !empty && (!out_valid || out_ready);
`ifdef ALU_ISSUE_FWD_EN
  logic [WIDTH-1:0] last_result_q;
  assign push_ent = {in_opcode, in_a, in_b, in_shamt, in_use_prev};
  assign op_a = head.use_prev ? last_result_q : head.a;
  always_ff @(posedge clk) begin
    if (rst) last_result_q <= '0;
    else if (issue) last_result_q <= alu_result;
  end
`else
  logic unused_use_prev;
  assign push_ent = {in_opcode, in_a, in_b, in_shamt, 1'b0};
  assign op_a = head.a;
  assign unused_use_prev = in_use_prev ^ head.use_prev;
`endif
  alu_issue_fifo #(.T(ent_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(issue),
    .data_i(push_ent),
    .head_o(head),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
  assign alu_opcode = empty ? '0 : head.opcode;
  assign alu_input1 = empty ? '0 : op_a;
  assign alu_input2 = empty ? '0 : head.b;
  assign alu_shift = empty ? '0 : head.shamt;
  // An issue while FULL and out_ready reloads the slot, giving one result per cycle.
  always_comb begin
    state_d = issue ? SLOT_FULL : (out_valid && out_ready) ? SLOT_EMPTY : state_q;
    result_d = issue ? alu_result : result_q;
    carry_d = issue ? alu_carry : carry_q;
    zero_d = issue ? alu_zero : zero_q;
    sign_d = issue ? alu_sign : sign_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      result_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      sign_q <= sign_d;
    end
  end
  assign out_valid = state_q == SLOT_FULL;
  assign out_result = result_q;
  assign out_carry = carry_q;
  assign out_zero = zero_q;
  assign out_sign = sign_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;
  localparam int DEPTH = 4;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {logic [7:0] r; logic c, z, s;} res_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, in_use_prev = 1'b0;
  logic [3:0] in_opcode = '0, alu_opcode;
  logic [7:0] in_a = '0, in_b = '0, alu_input1, alu_input2, alu_result, out_result;
  logic [4:0] in_shamt = '0, alu_shift;
  logic alu_carry, alu_zero, alu_sign, out_valid, out_ready = 1'b0, out_carry, out_zero, out_sign;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;
  res_t mq[$];
  bit msv = 1'b0;
  res_t mslot = '0;
  logic [7:0] mlast = '0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_use_prev(in_use_prev),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_sign(out_sign), .count(count)
  );
  // Stand-in ALU: carry is carry-out for ADD and borrow for SUB; unknown opcodes give 0.
  function automatic res_t alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
    logic [8:0] w;
    res_t o;
    case (op)
      4'd0: w = {1'b0, a} + {1'b0, b};
      4'd1: w = {1'b0, a} - {1'b0, b};
      4'd2: w = {1'b0, a & b};
      4'd3: w = {1'b0, a | b};
      4'd4: w = {1'b0, a << sh};
      default: w = 9'd0;
    endcase
    o.r = w[7:0];
    o.c = w[8];
    o.z = w[7:0] == 8'd0;
    o.s = w[7];
    return o;
  endfunction
  always_comb {alu_result, alu_carry, alu_zero, alu_sign} = alu_f(alu_opcode, alu_input1, alu_input2, alu_shift);
  // One clock: drive inputs, advance the model by the same edge, sample 1 time unit after it.
  task automatic cyc(input bit r, input bit v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [4:0] sh, input bit up, input bit od);
    bit acc, iss;
    res_t e;
    rst = r; in_valid = v; in_opcode = op; in_a = a; in_b = b; in_shamt = sh; in_use_prev = up; out_ready = od;
    if (r) begin
      mq.delete(); msv = 1'b0; mslot = '0; mlast = '0;
    end else begin
      acc = v && mq.size() < DEPTH;
      iss = mq.size() > 0 && (!msv || od);
      if (iss) begin mslot = mq.pop_front(); msv = 1'b1; end
      else if (msv && od) msv = 1'b0;
      if (acc) begin
        e = alu_f(op, (FWD && up) ? mlast : a, b, sh);
        mlast = e.r;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    cyc(1, 1, 4'd0, 8'h11, 8'h22, 5'd0, 0, 1);
    cyc(1, 1, 4'd0, 8'h11, 8'h22, 5'd0, 0, 1);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if ({out_result, out_carry, out_zero, out_sign} !== 11'd0) begin miscompares++;
      $display("FAIL reset_slot: got %h/%b%b%b want 00/000", out_result, out_carry, out_zero, out_sign); end
    vectors++; if ({alu_opcode, alu_input1, alu_input2, alu_shift} !== 25'd0) begin miscompares++;
      $display("FAIL reset_alu_drive: got %h want 0", {alu_opcode, alu_input1, alu_input2, alu_shift}); end
  endtask
  task automatic test_alu_ops();
    logic [3:0] op_t [5] = '{4'd0, 4'd1, 4'd1, 4'd4, 4'd4};
    logic [7:0] a_t [5] = '{8'h0F, 8'h05, 8'h01, 8'h81, 8'h81};
    logic [7:0] b_t [5] = '{8'h01, 8'h05, 8'h02, 8'h00, 8'h00};
    logic [4:0] sh_t [5] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd9};
    logic [7:0] r_t [5] = '{8'h10, 8'h00, 8'hFF, 8'h02, 8'h00};
    logic z_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic s_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, op_t[i], a_t[i], b_t[i], sh_t[i], 0, 1);
      vectors++; if (out_valid !== 1'b0 || count !== 3'd1) begin miscompares++;
        $display("FAIL op%0d_latency: got valid=%b count=%0d want valid=0 count=1", i, out_valid, count); end
      cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL op%0d_valid: got %b want 1", i, out_valid); end
      vectors++; if ({out_result, out_zero, out_sign} !== {r_t[i], z_t[i], s_t[i]}) begin miscompares++;
        $display("FAIL op%0d_result: got %h z=%b s=%b want %h z=%b s=%b", i, out_result, out_zero, out_sign, r_t[i], z_t[i], s_t[i]); end
      cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL op%0d_drain: got %b want 0", i, out_valid); end
    end
  endtask
  task automatic test_backpressure();
    res_t exp_r [6];
    for (int i = 0; i < 6; i++) begin
      exp_r[i] = alu_f(4'd0, 8'(i * 16 + 1), 8'(i), 5'd0);
      cyc(0, 1, 4'd0, 8'(i * 16 + 1), 8'(i), 5'd0, 0, 0);
    end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_result !== exp_r[i].r) begin miscompares++;
        $display("FAIL bp_order%0d: got valid=%b %h want valid=1 %h", i, out_valid, out_result, exp_r[i].r); end
      cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
    end
    vectors++; if (out_valid !== 1'b0 || count !== 3'd0) begin miscompares++;
      $display("FAIL bp_drained: got valid=%b count=%0d want 0/0", out_valid, count); end
  endtask
  task automatic test_forward();
    cyc(0, 1, 4'd0, 8'h03, 8'h04, 5'd0, 0, 1);
    cyc(0, 1, 4'd0, 8'h77, 8'h01, 5'd0, 1, 1);
    vectors++; if (out_valid !== 1'b1 || out_result !== 8'h07) begin miscompares++;
      $display("FAIL fwd_first: got valid=%b %h want 1 07", out_valid, out_result); end
    cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
    vectors++; if (out_valid !== 1'b1 || out_result !== (FWD ? 8'h08 : 8'h78)) begin miscompares++;
      $display("FAIL fwd_second: got valid=%b %h want 1 %h", out_valid, out_result, FWD ? 8'h08 : 8'h78); end
    cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'd0, 8'(i + 1), 8'(i + 1), 5'd0, 0, 0);
    vectors++; if (count !== 3'd3 || out_valid !== 1'b1) begin miscompares++;
      $display("FAIL rmid_pre: got count=%0d valid=%b want 3/1", count, out_valid); end
    cyc(1, 1, 4'd0, 8'h05, 8'h05, 5'd0, 0, 0);
    vectors++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 8'h00 || in_ready !== 1'b0) begin miscompares++;
      $display("FAIL rmid_cleared: got count=%0d valid=%b res=%h rdy=%b want 0/0/00/0", count, out_valid, out_result, in_ready); end
    cyc(0, 1, 4'd0, 8'h01, 8'h01, 5'd0, 0, 1);
    cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
    vectors++; if (out_valid !== 1'b1 || out_result !== 8'h02) begin miscompares++;
      $display("FAIL rmid_first_add: got valid=%b %h want 1 02", out_valid, out_result); end
    cyc(0, 0, 4'd0, 8'h00, 8'h00, 5'd0, 0, 1);
  endtask
  task automatic test_random();
    bit r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 59) == 0;
      cyc(r, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          5'($urandom_range(0, 10)), 1'($urandom), $urandom_range(0, 2) != 0);
      vectors++; if (count !== 3'(mq.size())) begin miscompares++;
        $display("FAIL rnd%0d_count: got %0d want %0d", n, count, mq.size()); end
      vectors++; if (out_valid !== msv) begin miscompares++;
        $display("FAIL rnd%0d_valid: got %b want %b", n, out_valid, msv); end
      vectors++; if (in_ready !== (!r && mq.size() < DEPTH)) begin miscompares++;
        $display("FAIL rnd%0d_in_ready: got %b want %b", n, in_ready, !r && mq.size() < DEPTH); end
      if (msv) begin
        vectors++; if ({out_result, out_carry, out_zero, out_sign} !== mslot) begin miscompares++;
          $display("FAIL rnd%0d_slot: got %h c%b z%b s%b want %h c%b z%b s%b", n, out_result, out_carry, out_zero,
                   out_sign, mslot.r, mslot.c, mslot.z, mslot.s); end
      end
      if (mq.size() == 0) begin
        vectors++; if ({alu_opcode, alu_input1, alu_input2, alu_shift} !== 25'd0) begin miscompares++;
          $display("FAIL rnd%0d_idle_drive: got %h want 0", n, {alu_opcode, alu_input1, alu_input2, alu_shift}); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_forward();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Upstream issue stage for the generated 8-bit combinational ALUs (ADD/SUB/AND/OR/SLL, opcodes 0–4). It does three things:
- accepts operation packets over a valid/ready handshake and buffers them in a small in-order FIFO;
- drives the head entry onto the ALU's opcode/operand/shift inputs;
- captures the ALU's result and flags into a registered output slot with its own valid/ready handshake.

This gives the purely combinational ALU a pipelined, back-pressurable wrapper on the datapath.

## Interface
- WIDTH, 8, operand/result width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SHIFT_W, 5, shift-amount width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  packet offered
- in_ready  out  1  packet accepted when in_valid & in_ready at edge
- in_opcode  in  4  ALU opcode
- in_a, in_b  in  WIDTH  operands
- in_shamt  in  SHIFT_W  shift amount
- in_use_prev  in  1  replace operand A with previous result (see Configuration)
- alu_opcode  out  4  to ALU opcode
- alu_input1, alu_input2  out  WIDTH  to ALU operands
- alu_shift  out  SHIFT_W  to ALU shiftValue
- alu_result  in  WIDTH  from ALU
- alu_carry, alu_zero, alu_sign  in  1  from ALU flags
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes slot when out_valid & out_ready at edge
- out_result  out  WIDTH  registered result
- out_carry, out_zero, out_sign  out  1  registered flags
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
FIFO:
- Circular buffer with wrapping read/write pointers and an occupancy counter.
- `in_ready = !rst && count < DEPTH`. A pop in the same cycle does not raise in_ready when full; there is no full-bypass.

ALU drive:
- alu_* are driven combinationally from the head entry.
- When the FIFO is empty, all alu_* are 0.

Output slot (two states):
- EMPTY: out_valid = 0.
- FULL: out_valid = 1.

Issue:
- Condition: `count != 0 && (!out_valid || out_ready)`.
- On issue: the slot loads alu_result and the three flags, the FIFO pops, and the state is FULL.
- `out_valid & out_ready` with no issue: the slot goes to EMPTY.
- Issue while FULL and out_ready: the slot reloads and stays FULL, sustaining one result per cycle.

Push/pop interaction:
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.

Opcode handling:
- Opcodes 5–15 are forwarded unchanged. The block captures whatever the ALU returns (result 0).

last_result register:
- Loaded with alu_result on every issue.
- Reset value 0.

## Timing
- Reset values: count = 0, pointers = 0, out_valid = 0, out_result = 0, out_carry = out_zero = out_sign = 0, last_result = 0, in_ready = 0 while rst is high.
- Latency: a packet accepted at edge N becomes head after N. With the slot free it issues at edge N+1, and out_valid is high in the cycle after edge N+1.
- Throughput: one packet per cycle when out_ready is held high.
- Results leave in acceptance order.
- Reset mid-operation: FIFO contents and the slot contents are discarded. A packet offered in the reset cycle is not accepted.
- out_result and the flags are held stable while `out_valid & !out_ready`.

## Configuration
- Macro: ALU_ISSUE_FWD_EN.
- With ALU_ISSUE_FWD_EN defined:
  - if the head entry has use_prev = 1, alu_input1 = last_result instead of the stored in_a;
  - this holds whether or not the previous output has been consumed;
  - use_prev is stored in the FIFO.
- Without the macro:
  - in_use_prev is ignored and not stored;
  - alu_input1 is always the stored in_a;
  - the last_result register is not built.

## Structure
- Package alu_issue_pkg holds:
  - opcode constants OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SLL = 4;
  - OPC_W = 4 and SHIFT_W = 5;
  - a packed entry typedef {opcode, a, b, shamt, use_prev}.
- Sub-module alu_issue_fifo: parameterised synchronous FIFO on the entry type, providing push/pop, head, count and full/empty.
- The top level holds the output slot, the issue logic and the forwarding logic.

## Test plan
- Single ADD, a = 8'h0F, b = 8'h01, out_ready = 1 → out_valid high one cycle after acceptance; out_result = 8'h10, zero = 0, sign = 0.
- SUB, a = 8'h05, b = 8'h05 → out_result = 8'h00, out_zero = 1. SUB, a = 8'h01, b = 8'h02 → out_result = 8'hFF, out_sign = 1.
- out_ready = 0, push 6 packets → 1 result held in the slot, count = 4, in_ready = 0, 6th packet not accepted. Then raise out_ready → 5 results in order on consecutive cycles.
- SLL, a = 8'h81, shamt = 1 → 8'h02. SLL with shamt = 9 → 8'h00, zero = 1.
- With ALU_ISSUE_FWD_EN: ADD 3+4, then ADD use_prev = 1, a = 8'h77, b = 1 → results 8'h07 then 8'h08. Without the macro, the same stimulus → 8'h07 then 8'h78.
- Assert rst with 3 queued and the slot full → next cycle count = 0, out_valid = 0, out_result = 0. The first post-reset ADD 1+1 yields 8'h02.
